// File: rtl/spdif_transmitter.sv
// spdif_transmitter: IEC 60958 biphase-mark line encoder.
// 192-frame blocks, B/M/W preambles, one-entry sample holding register.
module spdif_transmitter #(
  parameter int          CLK_DIV = 8,
  parameter logic [31:0] CS_WORD = 32'h0000_0004
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic [23:0] sample_left,
  input  logic [23:0] sample_right,
  input  logic        sample_vbit,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        spdif_out,
  output logic        block_start,
  output logic        underrun,
  output logic [7:0]  frame_index
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  logic [DW-1:0] div_q, div_d;
  logic [6:0]    ui_q, ui_d;
  logic [7:0]    frame_q, frame_d;
  logic          out_q, out_d;
  logic          pre_lvl_q, pre_lvl_d;
  logic          bs_q, bs_d;
  logic          und_q, und_d;
  logic          hold_full_q, hold_full_d;
  logic [23:0]   hold_l_q, hold_l_d;
  logic [23:0]   hold_r_q, hold_r_d;
  logic          hold_v_q, hold_v_d;
  logic [23:0]   act_l_q, act_l_d;
  logic [23:0]   act_r_q, act_r_d;
  logic          act_v_q, act_v_d;

  logic          ui_tick;
  logic          frame_start;
  logic          load;
  logic          sub_b;
  logic          half;
  logic [4:0]    slot;
  logic [4:0]    bit_idx;
  logic [2:0]    pre_k;
  logic [7:0]    pre_pat;
  logic          pre_ref;
  logic [23:0]   aud;
  logic          cs_bit;
  logic          parity;
  logic          data_bit;
  logic          line_bit;

  assign ui_tick     = tx_enable && (div_q == DIV_MAX);
  assign frame_start = ui_tick && (ui_q == 7'd0);
  assign load        = sample_valid && !hold_full_q;
  assign sub_b       = ui_q[6];
  assign slot        = ui_q[5:1];
  assign half        = ui_q[0];
  assign pre_k       = ui_q[2:0];
  assign bit_idx     = slot - 5'd4;

  assign sample_ready = !hold_full_q;
  assign spdif_out    = out_q;
  assign block_start  = bs_q;
  assign underrun     = und_q;
  assign frame_index  = frame_q;

  // Line level for the UI currently addressed by ui_q
  always_comb begin
    aud      = sub_b ? act_r_q : act_l_q;
    cs_bit   = (frame_q < 8'd32) ? CS_WORD[frame_q[4:0]] : 1'b0;
    parity   = ^aud ^ act_v_q ^ cs_bit;
    pre_pat  = sub_b ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
    pre_ref  = (pre_k == 3'd0) ? out_q : pre_lvl_q;
    data_bit = 1'b0;
    unique case (1'b1)
      (slot <= 5'd27): data_bit = aud[bit_idx];
      (slot == 5'd28): data_bit = act_v_q;
      (slot == 5'd29): data_bit = 1'b0;
      (slot == 5'd30): data_bit = cs_bit;
      (slot == 5'd31): data_bit = parity;
    endcase
    if (ui_q[5:3] == 3'd0) begin
      line_bit = pre_pat[3'd7 - pre_k] ^ pre_ref;
    end else if (!half) begin
      line_bit = ~out_q;
    end else begin
      line_bit = out_q ^ data_bit;
    end
  end

  // Next state for counters, line, holding and active registers
  always_comb begin
    div_d       = div_q;
    ui_d        = ui_q;
    frame_d     = frame_q;
    out_d       = out_q;
    pre_lvl_d   = pre_lvl_q;
    bs_d        = 1'b0;
    und_d       = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_v_d    = hold_v_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    act_v_d     = act_v_q;
    if (load) begin
      hold_full_d = 1'b1;
      hold_l_d    = sample_left;
      hold_r_d    = sample_right;
      hold_v_d    = sample_vbit;
    end else if (frame_start && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (!tx_enable) begin
      div_d     = '0;
      ui_d      = 7'd0;
      frame_d   = 8'd0;
      out_d     = 1'b0;
      pre_lvl_d = 1'b0;
      act_l_d   = 24'd0;
      act_r_d   = 24'd0;
      act_v_d   = 1'b0;
    end else begin
      div_d = ui_tick ? '0 : div_q + 1'b1;
      bs_d  = frame_start && (frame_q == 8'd0);
      und_d = frame_start && !hold_full_q;
      if (ui_tick) begin
        ui_d  = ui_q + 7'd1;
        out_d = line_bit;
        if (ui_q[5:0] == 6'd0) pre_lvl_d = out_q;
        if (ui_q == 7'd127) begin
          frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
        end
      end
      if (frame_start) begin
        act_l_d = hold_full_q ? hold_l_q : 24'd0;
        act_r_d = hold_full_q ? hold_r_q : 24'd0;
        act_v_d = hold_full_q ? hold_v_q : 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      ui_q        <= 7'd0;
      frame_q     <= 8'd0;
      out_q       <= 1'b0;
      pre_lvl_q   <= 1'b0;
      bs_q        <= 1'b0;
      und_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= 24'd0;
      hold_r_q    <= 24'd0;
      hold_v_q    <= 1'b0;
      act_l_q     <= 24'd0;
      act_r_q     <= 24'd0;
      act_v_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      ui_q        <= ui_d;
      frame_q     <= frame_d;
      out_q       <= out_d;
      pre_lvl_q   <= pre_lvl_d;
      bs_q        <= bs_d;
      und_q       <= und_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_v_q    <= hold_v_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      act_v_q     <= act_v_d;
    end
  end

endmodule

// File: tb/tb_spdif_transmitter.sv
// tb_spdif_transmitter: scoreboard bench, decodes the BMC line
// and compares every subframe with a queue-based sample model.
module tb_spdif_transmitter;

  localparam int DIV = 2;
  localparam int FR  = 128 * DIV;
  localparam logic [31:0] CSW = 32'h0000_0004;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_enable = 1'b0;
  logic [23:0] sample_left = 24'd0;
  logic [23:0] sample_right = 24'd0;
  logic        sample_vbit = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        spdif_out;
  logic        block_start;
  logic        underrun;
  logic [7:0]  frame_index;

  always #5 clk_sys = ~clk_sys;

  spdif_transmitter #(.CLK_DIV(DIV), .CS_WORD(CSW)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_enable(tx_enable),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_vbit(sample_vbit), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .spdif_out(spdif_out),
    .block_start(block_start), .underrun(underrun),
    .frame_index(frame_index)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        v;
  } smp_t;

  typedef struct {
    smp_t s;
    int   fr;
    bit   und;
  } exp_t;

  smp_t        hold_m[$];
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          en_cnt = 0;
  int          mframe = 0;
  int          mode = 0;
  bit          took = 1'b0;
  int          frames_dec = 0;
  logic [23:0] cnt = 24'd0;
  logic        ui_buf[128];
  int          uidx = 0;
  logic        lvl = 1'b0;
  logic [31:0] csw = CSW;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Enabled-cycle counter: UI k is on the line after edge (k+1)*DIV
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else if (tx_enable) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end

  // Reference model: one-entry holding register seen as a queue
  initial forever begin
    @(posedge clk_sys);
    if (!rst_n) begin
      hold_m.delete();
      exp_q.delete();
      mframe = 0;
    end else begin
      if (!tx_enable) begin
        exp_q.delete();
        mframe = 0;
      end else if (en_cnt % FR == DIV - 1) begin
        exp_t e;
        if (hold_m.size() > 0) begin
          e.s   = hold_m.pop_front();
          e.und = 1'b0;
        end else begin
          e.s   = '{24'd0, 24'd0, 1'b1};
          e.und = 1'b1;
        end
        e.fr = mframe;
        exp_q.push_back(e);
        mframe = (mframe + 1) % 192;
      end
      if (sample_valid && sample_ready) begin
        hold_m.push_back('{sample_left, sample_right, sample_vbit});
        took = 1'b1;
      end
    end
  end

  // Sample driver
  initial forever begin
    @(negedge clk_sys);
    if (took) begin
      took = 1'b0;
      if (mode == 2) begin
        cnt = cnt + 24'd1;
        sample_left  = cnt;
        sample_right = ~cnt;
        sample_vbit  = 1'($urandom % 2);
      end else begin
        sample_left  = 24'($urandom);
        sample_right = 24'($urandom);
        sample_vbit  = 1'($urandom % 2);
      end
    end
    sample_valid = (mode != 0);
  end

  task automatic decode_frame();
    exp_t        e;
    logic [31:0] bits;
    logic [7:0]  pre;
    logic [7:0]  want;
    logic        a;
    logic        b;
    int          bad;
    int          base;
    if (exp_q.size() == 0) begin
      chk("expect_avail", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    frames_dec++;
    for (int sf = 0; sf < 2; sf++) begin
      base = sf * 64;
      bits = 32'd0;
      for (int k = 0; k < 8; k++) pre[7-k] = ui_buf[base+k] ^ lvl;
      lvl = ui_buf[base+7];
      bad = 0;
      for (int s = 4; s < 32; s++) begin
        a = ui_buf[base+2*s];
        b = ui_buf[base+2*s+1];
        if (a !== ~lvl) bad++;
        bits[s] = a ^ b;
        lvl = b;
      end
      if (sf == 1) want = 8'b1110_0100;
      else if (e.fr == 0) want = 8'b1110_1000;
      else want = 8'b1110_0010;
      chk("preamble", 32'(pre), 32'(want));
      chk("bmc_edges", 32'(bad), 32'd0);
      chk("audio", 32'(bits[27:4]), 32'(sf == 1 ? e.s.r : e.s.l));
      chk("vbit", 32'(bits[28]), 32'(e.s.v));
      chk("ubit", 32'(bits[29]), 32'd0);
      chk("cbit", 32'(bits[30]), 32'(e.fr < 32 ? csw[e.fr] : 1'b0));
      chk("parity", 32'(^bits[31:4]), 32'd0);
    end
  endtask

  // Monitor: strobes, ready, line capture and frame decode
  initial forever begin
    @(negedge clk_sys);
    if (!rst_n) begin
      uidx = 0;
      lvl  = 1'b0;
      chk("rst_spdif", 32'(spdif_out), 32'd0);
      chk("rst_ready", 32'(sample_ready), 32'd1);
      chk("rst_frame_index", 32'(frame_index), 32'd0);
      chk("rst_strobes", 32'({block_start, underrun}), 32'd0);
    end else begin
      chk("ready", 32'(sample_ready), 32'(hold_m.size() == 0));
      if (en_cnt == 0) begin
        uidx = 0;
        lvl  = 1'b0;
        chk("idle_line", 32'(spdif_out), 32'd0);
      end
      if (en_cnt > 0 && en_cnt % FR == DIV) begin
        if (exp_q.size() == 0) begin
          chk("frame_expect", 32'd0, 32'd1);
        end else begin
          chk("block_start", 32'(block_start), 32'(exp_q[$].fr == 0));
          chk("underrun", 32'(underrun), 32'(exp_q[$].und));
          chk("frame_index", 32'(frame_index), 32'(exp_q[$].fr));
        end
      end else begin
        chk("strobes_idle", 32'({block_start, underrun}), 32'd0);
      end
      if (en_cnt > 0 && en_cnt % DIV == 0) begin
        ui_buf[uidx] = spdif_out;
        uidx++;
        if (uidx == 128) begin
          decode_frame();
          uidx = 0;
        end
      end
    end
  end

  initial begin
    sample_left  = 24'h000001;
    sample_right = 24'h800000;
    sample_vbit  = 1'b0;
    mode = 1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    #1 rst_n = 1'b1;
    tx_enable = 1'b1;
    repeat (FR * 2 + 100) @(negedge clk_sys);
    #1 rst_n = 1'b0;
    mode = 0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    #1 rst_n = 1'b1;
    repeat (FR * 3) @(negedge clk_sys);
    mode = 2;
    repeat (FR * 200) @(negedge clk_sys);
    for (int i = 0; i < FR && (en_cnt % FR != 95 * DIV); i++) begin
      @(negedge clk_sys);
    end
    chk("stop_point", 32'(en_cnt % FR), 32'(95 * DIV));
    tx_enable = 1'b0;
    repeat (50) @(negedge clk_sys);
    tx_enable = 1'b1;
    repeat (FR * 3 + DIV) @(negedge clk_sys);
    mode = 0;
    repeat (FR) @(negedge clk_sys);
    chk("frames_decoded", 32'(frames_dec >= 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
